// File: rtl/vga_console_ctrl_pkg.sv
// Shared definitions for the 64x24 text-console write sequencer: grid
// geometry, control codes, FSM state encoding and a tab-stop helper.
package vga_console_ctrl_pkg;

  // Visible character grid and coordinate widths
  localparam int COLS_MAX = 64;
  localparam int ROWS_VIS = 24;
  localparam int X_W      = 6;
  localparam int Y_W      = 5;

  // Control codes interpreted by the console
  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_CLRROW = 2'd2
  } state_t;

  // Next tab stop after column x, one bit wider so an overflow past the
  // last column is visible to the caller. tab_width must be a power of two.
  function automatic logic [X_W:0] next_tab_stop(input logic [X_W-1:0] x,
                                                 input int tab_width);
    logic [X_W:0] mask;
    mask = (X_W+1)'(tab_width - 1);
    return ({1'b0, x} | mask) + (X_W+1)'(1);
  endfunction

endpackage

// File: rtl/vga_console_ctrl_cell_sweeper.sv
// vga_cell_sweeper: row-major cell counter shared by the full-screen clear
// and the single-row clear. Emits one cell per cycle while active and flags
// the final cell with o_done.
module vga_cell_sweeper
  import vga_console_ctrl_pkg::*;
#(
  parameter int COLS = COLS_MAX,
  parameter int ROWS = ROWS_VIS
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_row_only,
  input  logic [Y_W-1:0] i_row,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_valid,
  output logic           o_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_active;
  logic           r_row_only;
  logic           w_last;

  assign w_last  = (r_x == X_LAST) && (r_row_only || (r_y == Y_LAST));
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_valid = r_active;
  assign o_done  = r_active && w_last;

  // Cell counter; reset leaves it running a full sweep from (0,0) so the
  // screen is blanked at power-on without any start request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_active   <= 1'b1;
      r_row_only <= 1'b0;
    end else if (i_start) begin
      r_x        <= '0;
      r_y        <= i_row_only ? i_row : '0;
      r_active   <= 1'b1;
      r_row_only <= i_row_only;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
      end else if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_console_ctrl.sv
// vga_console_ctrl: terminal-style sequencer driving the text-mode VGA
// character write port. Accepts a byte stream, tracks the cursor, decodes
// control codes and runs blanking sweeps through vga_cell_sweeper.
// Optional feature macro: VGA_CONSOLE_CLRROW_EN (blank each newly entered row).
module vga_console_ctrl
  import vga_console_ctrl_pkg::*;
#(
  parameter int         COLS      = COLS_MAX,
  parameter int         ROWS      = ROWS_VIS,
  parameter int         TAB_WIDTH = 4,
  parameter logic [7:0] BLANK     = 8'h00
) (
  input  logic           CLOCK_50,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  input  logic [23:0]    fg_color,
  input  logic [23:0]    bg_color,
  output logic           charWr,
  output logic [23:0]    charWrFgColor,
  output logic [23:0]    charWrBgColor,
  output logic [7:0]     charWrCode,
  output logic [X_W-1:0] charWrX,
  output logic [Y_W-1:0] charWrY,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y,
  output logic           busy
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);
  localparam logic [X_W:0]   COLS_EXT = (X_W+1)'(COLS);

`ifdef VGA_CONSOLE_CLRROW_EN
  localparam bit CLRROW_EN = 1'b1;
`else
  localparam bit CLRROW_EN = 1'b0;
`endif

  function automatic logic [Y_W-1:0] y_advance(input logic [Y_W-1:0] y);
    return (y == Y_LAST) ? '0 : y + Y_W'(1);
  endfunction

  state_t         r_state;
  logic [23:0]    r_bg_lat;

  state_t         w_state_next;
  logic           w_accept;
  logic [X_W:0]   w_tab_next;
  logic [X_W-1:0] w_x_next;
  logic [Y_W-1:0] w_y_next;
  logic           w_row_adv;
  logic           w_byte_wr;
  logic [X_W-1:0] w_wr_x;
  logic [Y_W-1:0] w_wr_y;
  logic [7:0]     w_wr_code;
  logic [23:0]    w_wr_fg;
  logic [23:0]    w_wr_bg;
  logic           w_sweep_start;
  logic           w_sweep_row_only;
  logic [Y_W-1:0] w_sweep_row;
  logic [X_W-1:0] w_sweep_x;
  logic [Y_W-1:0] w_sweep_y;
  logic           w_sweep_valid;
  logic           w_sweep_done;
  logic           w_sweep_wr;
  logic           w_busy_next;

  // in_ready is registered high only when the FSM sits in IDLE, so a
  // handshake implies the IDLE decode path below.
  assign w_accept   = in_valid && in_ready;
  assign w_tab_next = next_tab_stop(cursor_x, TAB_WIDTH);
  assign w_sweep_wr = (r_state != S_IDLE) && w_sweep_valid;
  // Busy covers the sweep states plus the cycle carrying the last sweep write.
  assign w_busy_next = (w_state_next != S_IDLE) || w_sweep_wr;

  vga_cell_sweeper #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sweeper (
    .i_clk      (CLOCK_50),
    .i_rst      (rst),
    .i_start    (w_sweep_start),
    .i_row_only (w_sweep_row_only),
    .i_row      (w_sweep_row),
    .o_x        (w_sweep_x),
    .o_y        (w_sweep_y),
    .o_valid    (w_sweep_valid),
    .o_done     (w_sweep_done)
  );

  // Byte decode, cursor movement and next-state selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_next     = r_state;
    w_x_next         = cursor_x;
    w_y_next         = cursor_y;
    w_row_adv        = 1'b0;
    w_byte_wr        = 1'b0;
    w_wr_x           = cursor_x;
    w_wr_y           = cursor_y;
    w_wr_code        = in_data;
    w_wr_fg          = fg_color;
    w_wr_bg          = bg_color;
    w_sweep_start    = 1'b0;
    w_sweep_row_only = 1'b0;
    w_sweep_row      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (in_data)
            CC_LF: begin
              w_x_next  = '0;
              w_y_next  = y_advance(cursor_y);
              w_row_adv = 1'b1;
            end
            CC_CR: w_x_next = '0;
            CC_TAB: begin
              if (w_tab_next >= COLS_EXT) begin
                w_x_next  = '0;
                w_y_next  = y_advance(cursor_y);
                w_row_adv = 1'b1;
              end else begin
                w_x_next = w_tab_next[X_W-1:0];
              end
            end
            CC_BS: begin
              // Backspace blanks with the background currently latched.
              w_wr_code = BLANK;
              w_wr_fg   = r_bg_lat;
              w_wr_bg   = r_bg_lat;
              if (cursor_x != '0) begin
                w_x_next  = cursor_x - X_W'(1);
                w_wr_x    = cursor_x - X_W'(1);
                w_byte_wr = 1'b1;
              end else if (cursor_y != '0) begin
                w_x_next  = X_LAST;
                w_y_next  = cursor_y - Y_W'(1);
                w_wr_x    = X_LAST;
                w_wr_y    = cursor_y - Y_W'(1);
                w_byte_wr = 1'b1;
              end
            end
            CC_FF: begin
              w_state_next  = S_CLEAR;
              w_sweep_start = 1'b1;
            end
            default: begin
              w_byte_wr = 1'b1;
              if (cursor_x == X_LAST) begin
                w_x_next  = '0;
                w_y_next  = y_advance(cursor_y);
                w_row_adv = 1'b1;
              end else begin
                w_x_next = cursor_x + X_W'(1);
              end
            end
          endcase
        end
      end
      S_CLEAR: begin
        if (w_sweep_done) begin
          w_state_next = S_IDLE;
          w_x_next     = '0;
          w_y_next     = '0;
        end
      end
      S_CLRROW: begin
        if (w_sweep_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Entering a new row blanks it when the row-clear feature is built in.
    if (CLRROW_EN && w_row_adv) begin
      w_state_next     = S_CLRROW;
      w_sweep_start    = 1'b1;
      w_sweep_row_only = 1'b1;
      w_sweep_row      = w_y_next;
    end
  end

  // FSM state, cursor and all registered outputs.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state       <= S_CLEAR;
      r_bg_lat      <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      charWr        <= 1'b0;
      charWrFgColor <= '0;
      charWrBgColor <= '0;
      charWrCode    <= '0;
      charWrX       <= '0;
      charWrY       <= '0;
      cursor_x      <= '0;
      cursor_y      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state  <= w_state_next;
      cursor_x <= w_x_next;
      cursor_y <= w_y_next;
      busy     <= w_busy_next;
      in_ready <= !w_busy_next;
      if (w_accept) r_bg_lat <= bg_color;

      if (w_sweep_wr) begin
        charWr        <= 1'b1;
        charWrX       <= w_sweep_x;
        charWrY       <= w_sweep_y;
        charWrCode    <= BLANK;
        charWrFgColor <= r_bg_lat;
        charWrBgColor <= r_bg_lat;
      end else if (w_byte_wr) begin
        charWr        <= 1'b1;
        charWrX       <= w_wr_x;
        charWrY       <= w_wr_y;
        charWrCode    <= w_wr_code;
        charWrFgColor <= w_wr_fg;
        charWrBgColor <= w_wr_bg;
      end else begin
        charWr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl: expected cell writes are queued as
// stimulus is driven and checked as charWr pulses appear.
// Honours VGA_CONSOLE_CLRROW_EN when the design is built with it.
module tb_vga_console_ctrl;

  localparam logic [23:0] C_FG = 24'h123456;
  localparam logic [23:0] C_BG = 24'h654321;

  typedef struct packed {
    logic [5:0]  x;
    logic [4:0]  y;
    logic [7:0]  code;
    logic [23:0] fg;
    logic [23:0] bg;
    logic        chk_col;
  } exp_t;

  logic        CLOCK_50;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [23:0] fg_color;
  logic [23:0] bg_color;
  logic        charWr;
  logic [23:0] charWrFgColor;
  logic [23:0] charWrBgColor;
  logic [7:0]  charWrCode;
  logic [5:0]  charWrX;
  logic [4:0]  charWrY;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   g_wait  = 0;

  vga_console_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .fg_color      (fg_color),
    .bg_color      (bg_color),
    .charWr        (charWr),
    .charWrFgColor (charWrFgColor),
    .charWrBgColor (charWrBgColor),
    .charWrCode    (charWrCode),
    .charWrX       (charWrX),
    .charWrY       (charWrY),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .busy          (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [5:0] x, input logic [4:0] y, input logic [7:0] code,
                         input logic [23:0] fg, input logic [23:0] bg, input logic chk);
    exp_t e;
    e.x = x; e.y = y; e.code = code; e.fg = fg; e.bg = bg; e.chk_col = chk;
    sb.push_back(e);
  endtask

  task automatic push_clear(input logic [23:0] bg);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 64; x++)
        push_wr(6'(x), 5'(y), 8'h00, bg, bg, 1'b1);
  endtask

  // Row blanking only exists when the design is built with the feature.
  task automatic push_row(input logic [4:0] y);
`ifdef VGA_CONSOLE_CLRROW_EN
    for (int x = 0; x < 64; x++) push_wr(6'(x), y, 8'h00, 24'h0, 24'h0, 1'b0);
`else
    if (y > 5'd23) $display("[TB] row %0d out of range", y);
`endif
  endtask

  // Offer one byte starting at a negedge; returns at the negedge after the
  // transfer and checks whether that cycle carries a write.
  task automatic send(input logic [7:0] b, input logic [23:0] fg, input logic [23:0] bg,
                      input logic exp_wr);
    logic acc, rdy;
    int   n;
    acc = 1'b0; n = 0;
    in_valid = 1'b1; in_data = b; fg_color = fg; bg_color = bg;
    while (!acc && n < 5000) begin
      rdy = in_ready;
      @(posedge CLOCK_50);
      acc = rdy;
      n++;
      @(negedge CLOCK_50);
    end
    in_valid = 1'b0;
    g_wait = n;
    check("byte_accepted", 64'(acc), 64'd1);
    if (acc) check("write_after_accept", 64'(charWr), 64'(exp_wr));
  endtask

  task automatic cursor_is(input string tag, input logic [5:0] x, input logic [4:0] y);
    check(tag, {cursor_x, cursor_y}, {x, y});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
    check("drain_ready", 64'(in_ready), 64'd1);
  endtask

  // Full sweep: exactly 1536 busy cycles, then idle at (0,0).
  task automatic run_clear();
    int bad;
    bad = 0;
    repeat (1536) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("clear_busy_cycles", 64'(bad), 64'd0);
    @(negedge CLOCK_50);
    check("clear_end_busy_ready", {busy, in_ready}, 2'b01);
    cursor_is("clear_end_cursor", 6'd0, 5'd0);
    check("clear_all_cells", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge CLOCK_50) begin
    exp_t e;
    bit   have;
    if (charWr === 1'b1) begin
      have = (sb.size() > 0);
      check("write_expected", 64'(have), 64'd1);
      if (have) begin
        e = sb.pop_front();
        check("write_cell", {charWrX, charWrY, charWrCode}, {e.x, e.y, e.code});
        if (e.chk_col) check("write_colour", {charWrFgColor, charWrBgColor}, {e.fg, e.bg});
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; fg_color = '0; bg_color = '0;
    #1 rst = 1'b1;

    // 1. Reset values, bytes offered during reset are ignored, power-on clear
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {in_ready, busy, charWr, charWrX, charWrY, charWrCode, cursor_x, cursor_y}, '0);
    check("reset_colours", {charWrFgColor, charWrBgColor}, '0);
    in_valid = 1'b0;
    push_clear(24'h0);
    rst = 1'b0;
    run_clear();

    // 2. Back-to-back printable bytes
    push_wr(6'd0, 5'd0, 8'h41, 24'hFFFFFF, 24'h0000FF, 1'b1);
    push_wr(6'd1, 5'd0, 8'h42, 24'hFFFFFF, 24'h0000FF, 1'b1);
    send(8'h41, 24'hFFFFFF, 24'h0000FF, 1'b1);
    send(8'h42, 24'hFFFFFF, 24'h0000FF, 1'b1);
    check("back_to_back", 64'(g_wait), 64'd1);
    cursor_is("cursor_after_AB", 6'd2, 5'd0);

    // 3. Printable at the last column wraps to the next row
    for (int i = 1; i <= 5; i++) begin
      push_row(5'(i));
      send(8'h0A, C_FG, C_BG, 1'b0);
    end
    cursor_is("cursor_after_5LF", 6'd0, 5'd5);
    repeat (15) send(8'h09, C_FG, C_BG, 1'b0);
    cursor_is("cursor_after_15TAB", 6'd60, 5'd5);
    for (int i = 0; i < 3; i++) begin
      push_wr(6'(60 + i), 5'd5, 8'h61 + 8'(i), C_FG, C_BG, 1'b1);
      send(8'h61 + 8'(i), C_FG, C_BG, 1'b1);
    end
    cursor_is("cursor_at_63_5", 6'd63, 5'd5);
    push_wr(6'd63, 5'd5, 8'h41, C_FG, C_BG, 1'b1);
    push_row(5'd6);
    send(8'h41, C_FG, C_BG, 1'b1);
    cursor_is("cursor_after_col_wrap", 6'd0, 5'd6);
    drain();

    // 4. LF on the last row wraps to row 0 without writing
    for (int i = 7; i <= 23; i++) begin
      push_row(5'(i));
      send(8'h0A, C_FG, C_BG, 1'b0);
    end
    cursor_is("cursor_at_0_23", 6'd0, 5'd23);
    push_row(5'd0);
    send(8'h0A, C_FG, C_BG, 1'b0);
    cursor_is("cursor_after_row_wrap", 6'd0, 5'd0);
    drain();

    // 5. Backspace across row start, within a row, and at the origin
    for (int i = 1; i <= 3; i++) begin
      push_row(5'(i));
      send(8'h0A, C_FG, C_BG, 1'b0);
    end
    push_wr(6'd63, 5'd2, 8'h00, 24'h0, 24'h0, 1'b0);
    send(8'h08, C_FG, C_BG, 1'b1);
    cursor_is("cursor_bs_row_start", 6'd63, 5'd2);
    push_wr(6'd62, 5'd2, 8'h00, 24'h0, 24'h0, 1'b0);
    send(8'h08, C_FG, C_BG, 1'b1);
    cursor_is("cursor_bs_mid_row", 6'd62, 5'd2);
    send(8'h0D, C_FG, C_BG, 1'b0);
    cursor_is("cursor_after_CR", 6'd0, 5'd2);
    push_wr(6'd63, 5'd1, 8'h00, 24'h0, 24'h0, 1'b0);
    send(8'h08, C_FG, C_BG, 1'b1);
    send(8'h0D, C_FG, C_BG, 1'b0);
    push_wr(6'd63, 5'd0, 8'h00, 24'h0, 24'h0, 1'b0);
    send(8'h08, C_FG, C_BG, 1'b1);
    send(8'h0D, C_FG, C_BG, 1'b0);
    send(8'h08, C_FG, C_BG, 1'b0);
    cursor_is("cursor_bs_origin", 6'd0, 5'd0);
    drain();

    // 6. Tabs, tab wrap, then form feed interrupted by reset
    for (int i = 1; i <= 4; i++) begin
      push_row(5'(i));
      send(8'h0A, C_FG, C_BG, 1'b0);
    end
    send(8'h09, C_FG, C_BG, 1'b0);
    send(8'h09, C_FG, C_BG, 1'b0);
    push_wr(6'd8, 5'd4, 8'h71, C_FG, C_BG, 1'b1);
    send(8'h71, C_FG, C_BG, 1'b1);
    push_wr(6'd9, 5'd4, 8'h72, C_FG, C_BG, 1'b1);
    send(8'h72, C_FG, C_BG, 1'b1);
    cursor_is("cursor_at_10_4", 6'd10, 5'd4);
    send(8'h09, C_FG, C_BG, 1'b0);
    cursor_is("cursor_tab_12_4", 6'd12, 5'd4);
    repeat (12) send(8'h09, C_FG, C_BG, 1'b0);
    cursor_is("cursor_tab_60_4", 6'd60, 5'd4);
    push_row(5'd5);
    send(8'h09, C_FG, C_BG, 1'b0);
    cursor_is("cursor_tab_wrap", 6'd0, 5'd5);
    drain();
    push_wr(6'd0, 5'd5, 8'h6D, C_FG, C_BG, 1'b1);
    send(8'h6D, C_FG, C_BG, 1'b1);
    for (int i = 0; i < 700; i++) push_wr(6'(i % 64), 5'(i / 64), 8'h00, 24'h00FF00, 24'h00FF00, 1'b1);
    send(8'h0C, C_FG, 24'h00FF00, 1'b0);
    repeat (700) @(negedge CLOCK_50);
    check("ff_sweep_busy", {busy, in_ready}, 2'b10);
    #1 rst = 1'b1;
    #2;
    check("midsweep_reset_outputs", {in_ready, busy, charWr, cursor_x, cursor_y}, '0);
    check("ff_sweep_700_cells", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge CLOCK_50);
    push_clear(24'h0);
    rst = 1'b0;
    run_clear();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
